nv_reset_sequencer: RTL

- Orders the release of NUM_DOM reset domains after a global reset or a software reset request.
- Each domain gets a programmable hold count and an acknowledge handshake. The ack is typically the domain's own synchronized reset-release indication.
- Sits above the per-domain reset synchronizers and drives their active-low reset inputs.
- Supports the test-mode bypass with direct_reset_, like the rest of the reset tree.

---
 rtl/nv_rst_seq_pkg.sv | 20 ++
 rtl/nv_rst_seq_cnt.sv | 24 ++
 rtl/nv_reset_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/nv_rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// watchdog sizing and an index-width helper.
package nv_rst_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT   = 2'd0,
      RELEASE  = 2'd1,
      WAIT_ACK = 2'd2,
      DONE     = 2'd3
   } seq_state_t;

   localparam int WDOG_W     = 10;
   localparam int WDOG_LIMIT = 1023;

   // Index width for a domain count; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nv_rst_seq_cnt.sv
// Loadable down-counter that stops at zero; used as the sequencer hold timer.
module nv_rst_seq_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (load) begin
         cnt <= load_val;
      end else if (dec && !zero) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/nv_reset_sequencer.sv
// Releases NUM_DOM reset domains in index order with per-domain hold and ack.
// Optional ack watchdog with sticky seq_err: define NV_RST_SEQ_ACK_WDOG_EN.
import nv_rst_seq_pkg::*;

module nv_reset_sequencer #(
   parameter int NUM_DOM  = 4,
   parameter int CNT_W    = 8,
   parameter int HOLD_DEF = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sw_rst_req,
   input  logic [NUM_DOM*CNT_W-1:0] dom_hold_cnt,
   input  logic [NUM_DOM-1:0]       dom_ack,
   input  logic                     test_mode,
   input  logic                     direct_reset_,
   output logic [NUM_DOM-1:0]       dom_rst_,
   output logic                     sw_rst_busy,
   output logic                     seq_done,
   output logic                     seq_err
);

   localparam int               IDX_W     = idx_width(NUM_DOM);
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_DEF - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOM - 1);

   seq_state_t         state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [NUM_DOM-1:0] rst_q;

   logic               cnt_load;
   logic [CNT_W-1:0]   cnt_load_val;
   logic               cnt_dec;
   logic               cnt_zero;

   logic               ack_sel;
   logic               last_dom;
   logic               wdog_to;
   logic               advance;

   logic [CNT_W-1:0]   hold_arr [NUM_DOM];

   for (genvar g = 0; g < NUM_DOM; g++) begin : g_hold
      assign hold_arr[g] = dom_hold_cnt[g*CNT_W +: CNT_W];
   end

   // Only the active domain's ack matters; a watchdog timeout counts as an ack.
   assign ack_sel  = dom_ack[idx];
   assign last_dom = (idx == LAST_IDX);
   assign idx_nxt  = idx + 1'b1;
   assign advance  = ack_sel | wdog_to;

   always_comb begin
      cnt_load     = 1'b0;
      cnt_load_val = HOLD_INIT;
      cnt_dec      = 1'b0;
      if (reset) begin
         cnt_load = 1'b1;
      end else begin
         case (state)
            ASSERT: begin
               if (cnt_zero) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = hold_arr[0];
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            RELEASE: begin
               cnt_dec = !cnt_zero;
            end
            WAIT_ACK: begin
               if (advance && !last_dom) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = hold_arr[idx_nxt];
               end
            end
            DONE: begin
               cnt_load = sw_rst_req;
            end
            default: begin
               cnt_load = 1'b1;
            end
         endcase
      end
   end

   nv_rst_seq_cnt #(
      .CNT_W    (CNT_W)
   ) u_hold_cnt (
      .clk      (clk),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ASSERT;
         idx         <= '0;
         rst_q       <= '0;
         seq_done    <= 1'b0;
         sw_rst_busy <= 1'b1;
      end else begin
         case (state)
            ASSERT: begin
               if (cnt_zero) begin
                  state <= RELEASE;
                  idx   <= '0;
               end
            end
            RELEASE: begin
               if (cnt_zero) begin
                  state      <= WAIT_ACK;
                  rst_q[idx] <= 1'b1;
               end
            end
            WAIT_ACK: begin
               if (advance) begin
                  if (last_dom) begin
                     state       <= DONE;
                     seq_done    <= 1'b1;
                     sw_rst_busy <= 1'b0;
                  end else begin
                     state <= RELEASE;
                     idx   <= idx_nxt;
                  end
               end
            end
            DONE: begin
               if (sw_rst_req) begin
                  state       <= ASSERT;
                  rst_q       <= '0;
                  seq_done    <= 1'b0;
                  sw_rst_busy <= 1'b1;
               end
            end
            default: begin
               state <= ASSERT;
            end
         endcase
      end
   end

`ifdef NV_RST_SEQ_ACK_WDOG_EN
   logic [WDOG_W-1:0] wdog;
   logic              err_q;

   // Counter idles at zero outside WAIT_ACK, so every entry starts from zero.
   // Timeout fires on the cycle whose increment would reach the limit.
   assign wdog_to = (state == WAIT_ACK) && (wdog == WDOG_W'(WDOG_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == WAIT_ACK) begin
            wdog <= wdog + 1'b1;
         end else begin
            wdog <= '0;
         end
         if (wdog_to && !ack_sel) begin
            err_q <= 1'b1;
         end else if (state == DONE && sw_rst_req) begin
            err_q <= 1'b0;
         end
      end
   end

   assign seq_err = err_q;
`else
   assign wdog_to = 1'b0;
   assign seq_err = 1'b0;
`endif

   // DFT bypass sits after the flops; the FSM keeps sequencing underneath.
   assign dom_rst_ = test_mode ? {NUM_DOM{direct_reset_}} : rst_q;

endmodule
